// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types, bit indices and direction encoder for the pushbutton front-end
package button_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bit positions inside the {up,down,left,right} vectors
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_RIGHT = 0;

    // Highest-priority pressed direction; UP wins over DOWN over LEFT over RIGHT
    function automatic dir_t encode_dir(input logic [3:0] pulses);
        if (pulses[BTN_UP]) begin
            return UP;
        end else if (pulses[BTN_DOWN]) begin
            return DOWN;
        end else if (pulses[BTN_LEFT]) begin
            return LEFT;
        end else begin
            return RIGHT;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one pin: 2-flop sync, debounce FSM, press pulse (auto-repeat under BTN_AUTOREPEAT_EN)
module btn_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned CNT_W           = 16
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 5000,
    parameter int unsigned REPEAT_RATE     = 1000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [1:0]       sync_q, sync_d;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             press_evt;
    logic             rpt_evt;
    logic             s;

    assign s = sync_q[1];

    // Synchroniser, FSM state, debounce counter and registered pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: a level change is accepted only after DEBOUNCE_CYCLES stable samples
    always_comb begin
        sync_d    = {sync_q[0], pin_n};
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (!s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [CNT_W-1:0] rpt_q, rpt_d;

    // Repeat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    // Runs only while staying in PRESSED; reload after each repeat so later gaps are REPEAT_RATE
    always_comb begin
        rpt_d   = '0;
        rpt_evt = 1'b0;
        if (state_q == PRESSED && !s) begin
            if (rpt_q >= RPT_FIRST) begin
                rpt_evt = 1'b1;
                rpt_d   = RPT_RELOAD;
            end else begin
                rpt_d = sat_inc(rpt_q);
            end
        end
    end
`else
    assign rpt_evt = 1'b0;
`endif

    // Outputs: level while held (including release bounce window), one-cycle pulse per event
    always_comb begin
        level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        pulse_d = press_evt | rpt_evt;
        pulse   = pulse_q;
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - four debounced active-low buttons plus priority direction strobe; option BTN_AUTOREPEAT_EN
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_DELAY    = 5000,
    parameter int unsigned REPEAT_RATE     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       dir_valid,
    output dir_t       dir
);

    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

    // Reject counter widths that cannot reach the programmed thresholds
    if (DEBOUNCE_CYCLES > CNT_LIMIT || REPEAT_DELAY > CNT_LIMIT ||
        REPEAT_RATE == 0 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
        $error("button_conditioner: CNT_W too narrow or repeat timing inconsistent");
    end

    logic [3:0] pin_n;
    dir_t       dir_q, dir_d;

    assign pin_n = {up, down, left, right};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE(REPEAT_RATE)
`endif
        ) u_db (
            .clk(clk),
            .rst_n(reset),
            .pin_n(pin_n[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end

    // Remember the last granted direction so dir is stable between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q <= UP;
        end else begin
            dir_q <= dir_d;
        end
    end

    // Priority encode the registered pulses; lower-priority simultaneous moves are dropped
    always_comb begin
        dir_valid = |btn_pulse;
        dir_d     = dir_valid ? encode_dir(btn_pulse) : dir_q;
        dir       = dir_d;
    end

endmodule
